// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHECK state).
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_DEPTH  = 256;
  localparam int unsigned INST_W      = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into one instruction word.
module byte_packer
  import imem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [7:0]        byte_i,
  output logic              word_full_c,
  output logic [INST_W-1:0] word_o
);

  localparam int unsigned IDX_W = $clog2(INST_W / 8);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((INST_W / 8) - 1);

  logic [IDX_W-1:0]  r_idx;
  logic [INST_W-1:0] r_word;

  // The byte that lands in the top lane completes the word.
  assign word_full_c = accept_i && (r_idx == LAST_IDX);
  assign word_o      = r_word;

  // Insert each accepted byte into its lane; the index wraps after the top lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (clear_i) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (accept_i) begin
      r_word[{r_idx, 3'b000} +: 8] <= byte_i;
      r_idx                        <= r_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills the icache from a byte stream and holds the core in reset until done.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing checksum byte, err_o).
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   nwords_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [INST_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              core_rst_no
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_n, w_n_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_we, r_busy, r_done, r_ready, r_core_rst_n;
  logic              w_we_nxt, w_busy_nxt, w_done_nxt, w_ready_nxt, w_core_rst_n_nxt;
  logic              w_start_c, w_accept_c, w_pack_c, w_word_full_c;
  logic              w_err_nxt;
  logic [CNT_W-1:0]  w_nsat_c;

`ifdef LOADER_CHECKSUM_EN
  logic       r_err;
  logic [7:0] r_sum, w_sum_nxt;
`endif

  assign w_accept_c = byte_valid_i && r_ready;
  assign w_pack_c   = w_accept_c && (r_state == COLLECT);
  assign w_nsat_c   = (nwords_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : nwords_i;

  byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (w_start_c),
    .accept_i    (w_pack_c),
    .byte_i      (byte_i),
    .word_full_c (w_word_full_c),
    .word_o      (wdata_o)
  );

  // State and load bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Next state, bookkeeping and next values of the registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_start_c   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    w_err_nxt   = r_err;
    w_sum_nxt   = r_sum;
`else
    w_err_nxt   = 1'b0;
`endif

    case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          w_start_c   = 1'b1;
          w_n_nxt     = w_nsat_c;
          w_cnt_nxt   = '0;
          w_addr_nxt  = '0;
          w_err_nxt   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          w_sum_nxt   = '0;
`endif
          w_state_nxt = (w_nsat_c == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_accept_c) w_sum_nxt = r_sum + byte_i;
`endif
        if (w_word_full_c) w_state_nxt = WRITE;
      end
      WRITE: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_cnt_nxt == r_n) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_nxt = CHECK;
`else
          w_state_nxt = DONE;
`endif
        end else begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (w_accept_c) begin
          w_err_nxt   = (8'(r_sum + byte_i) != 8'h00);
          w_state_nxt = DONE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase

    w_we_nxt         = (w_state_nxt == WRITE);
    w_ready_nxt      = (w_state_nxt == COLLECT) || (w_state_nxt == CHECK);
    w_busy_nxt       = (w_state_nxt == COLLECT) || (w_state_nxt == WRITE) ||
                       (w_state_nxt == CHECK);
    w_done_nxt       = (w_state_nxt == DONE);
    w_core_rst_n_nxt = (w_state_nxt == DONE) && !w_err_nxt;
  end

  // Registered handshake, strobe and status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we         <= 1'b0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_we         <= w_we_nxt;
      r_ready      <= w_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running byte sum and the checksum verdict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      r_sum <= w_sum_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign byte_ready_o = r_ready;
  assign we_o         = r_we;
  assign waddr_o      = r_addr;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign core_rst_no  = r_core_rst_n;

endmodule
